// File: rtl/v6525_pio_if.sv
// v6525_pio bus control: register select, direction and chip select.
// The tri-state data bus stays a plain inout on the block.
interface v6525_pio_if;
  logic [3:0] rs;
  logic       r_w;
  logic       _cs;

  modport master (
    output rs,
    output r_w,
    output _cs
  );

  modport slave (
    input rs,
    input r_w,
    input _cs
  );
endinterface

// File: rtl/v6525_pio.sv
// v6525_pio: parallel I/O ports behind a 6502-style bus, with an
// edge-triggered interrupt latch, mask and priority status register.
module v6525_pio #(
  parameter int NPORTS      = 3,
  parameter int WIDTH       = 8,
  parameter int NIRQ        = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    phi2,
  input  logic                    _reset,
  v6525_pio_if.slave              bus,
  inout  wire [WIDTH-1:0]         data,
  inout  wire [NPORTS*WIDTH-1:0]  port,
  input  logic [NIRQ-1:0]         irq_in,
  output wire                     _irq
);
  localparam int BW = $clog2(SYNC_STAGES + 2);
  localparam logic [BW-1:0] BLANK = BW'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] pdr_q [NPORTS];
  logic [WIDTH-1:0] pdr_d [NPORTS];
  logic [WIDTH-1:0] ddr_q [NPORTS];
  logic [WIDTH-1:0] ddr_d [NPORTS];
  logic [NIRQ-1:0]  ilr_q, ilr_d;
  logic [NIRQ-1:0]  imr_q, imr_d;
  logic [NIRQ-1:0]  ecr_q, ecr_d;
  logic [NIRQ-1:0]  sync_q [SYNC_STAGES];
  logic [NIRQ-1:0]  sync_d [SYNC_STAGES];
  logic [NIRQ-1:0]  hist_q, hist_d;
  logic [BW-1:0]    blank_q, blank_d;

  logic             wr;
  logic             rd;
  logic [NIRQ-1:0]  synced;
  logic [NIRQ-1:0]  edge_det;
  logic [NIRQ-1:0]  act;
  logic             pending;
  logic [WIDTH-1:0] stat;
  logic [WIDTH-1:0] rd_data;

  assign wr      = !bus._cs && !bus.r_w;
  assign rd      = !bus._cs && bus.r_w && phi2;
  assign synced  = sync_q[SYNC_STAGES-1];
  assign act     = ilr_q & imr_q;
  assign pending = |act;

  // Rewriting ECR re-arms detection, so that cycle never reports an edge.
  always_comb begin
    edge_det = '0;
    if (blank_q == '0 && !(wr && bus.rs == 4'd10))
      edge_det = (synced ^ hist_q) & ~(synced ^ ecr_q);
  end

  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      pdr_d[p] = pdr_q[p];
      ddr_d[p] = ddr_q[p];
    end
    imr_d = imr_q;
    ecr_d = ecr_q;
    ilr_d = ilr_q;
    sync_d[0] = irq_in;
    for (int s = 1; s < SYNC_STAGES; s++)
      sync_d[s] = sync_q[s-1];
    hist_d  = synced;
    blank_d = blank_q;
    if (blank_q != '0)
      blank_d = blank_q - BW'(1);
    if (wr) begin
      for (int p = 0; p < NPORTS; p++) begin
        if (bus.rs == 4'(p))
          pdr_d[p] = data;
        if (bus.rs == 4'(p + 4))
          ddr_d[p] = data;
      end
      unique case (1'b1)
        bus.rs == 4'd8:  ilr_d = ilr_q & ~data[NIRQ-1:0];
        bus.rs == 4'd9:  imr_d = data[NIRQ-1:0];
        bus.rs == 4'd10: ecr_d = data[NIRQ-1:0];
        default: ;
      endcase
    end
    // A fresh edge beats a same-cycle write-1-to-clear.
    ilr_d = ilr_d | edge_det;
  end

  always_comb begin
    stat = '0;
    stat[WIDTH-1] = pending;
    for (int k = NIRQ - 1; k >= 0; k--)
      if (act[k])
        stat[2:0] = 3'(k);
  end

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (bus.rs == 4'(p))
        rd_data = (pdr_q[p] & ddr_q[p]) |
                  (port[p*WIDTH +: WIDTH] & ~ddr_q[p]);
      if (bus.rs == 4'(p + 4))
        rd_data = ddr_q[p];
    end
    unique case (1'b1)
      bus.rs == 4'd8:  rd_data = WIDTH'(ilr_q);
      bus.rs == 4'd9:  rd_data = WIDTH'(imr_q);
      bus.rs == 4'd10: rd_data = WIDTH'(ecr_q);
      bus.rs == 4'd11: rd_data = stat;
      default: ;
    endcase
  end

  always_ff @(negedge phi2 or negedge _reset) begin
    if (!_reset) begin
      for (int p = 0; p < NPORTS; p++) begin
        pdr_q[p] <= '0;
        ddr_q[p] <= '0;
      end
      ilr_q <= '0;
      imr_q <= '0;
      ecr_q <= '0;
      for (int s = 0; s < SYNC_STAGES; s++)
        sync_q[s] <= '0;
      hist_q  <= '0;
      blank_q <= BLANK;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        pdr_q[p] <= pdr_d[p];
        ddr_q[p] <= ddr_d[p];
      end
      ilr_q <= ilr_d;
      imr_q <= imr_d;
      ecr_q <= ecr_d;
      for (int s = 0; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_d[s];
      hist_q  <= hist_d;
      blank_q <= blank_d;
    end
  end

  assign data = rd ? rd_data : 'z;
  assign _irq = pending ? 1'b0 : 1'bz;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign port[p*WIDTH+i] = ddr_q[p][i] ? pdr_q[p][i] : 1'bz;
    end
  end
endmodule
